// File: rtl/instr_cache_pkg.sv
// rtl/instr_cache_pkg.sv - shared types and width helpers for the instruction cache
//
// Purpose: FSM state encoding and the address-split width calculations used
// by both the cache controller and its storage arrays.
// Ports: none (package).

package instr_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } cache_state_t;

    // Word-offset bits (WOFF).
    function automatic int calc_woff(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Line-index bits (IDX).
    function automatic int calc_idx(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag bits (TAG_W): everything above index, word offset and byte offset.
    function automatic int calc_tag_w(input int address_width, input int num_lines,
                                      input int words_per_line);
        return address_width - $clog2(num_lines) - $clog2(words_per_line) - 2;
    endfunction

endpackage

// File: rtl/instr_cache_store.sv
// rtl/instr_cache_store.sv - valid/tag/data arrays for the direct-mapped instruction cache
//
// Purpose: holds per-line valid bit, tag and words.
// Ports:
//   clk, rst_n            - clock, async active-low reset (clears valid bits only)
//   rd_idx, rd_woff       - combinational read port address
//   rd_valid, rd_tag      - valid bit and tag of line rd_idx
//   rd_word               - word rd_woff of line rd_idx
//   wr_en, wr_idx, wr_woff, wr_data - one-word data write
//   tag_we, wr_tag        - write tag of line wr_idx and set its valid bit
//   flush_all             - clear every valid bit (wins over tag_we)

module instr_cache_store
    import instr_cache_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 24
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [calc_idx(NUM_LINES)-1:0]       rd_idx,
    input  logic [calc_woff(WORDS_PER_LINE)-1:0] rd_woff,
    output logic                                 rd_valid,
    output logic [TAG_W-1:0]                     rd_tag,
    output logic [DATA_WIDTH-1:0]                rd_word,
    input  logic                                 wr_en,
    input  logic [calc_idx(NUM_LINES)-1:0]       wr_idx,
    input  logic [calc_woff(WORDS_PER_LINE)-1:0] wr_woff,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 tag_we,
    input  logic [TAG_W-1:0]                     wr_tag,
    input  logic                                 flush_all
);

    localparam int IDX  = calc_idx(NUM_LINES);
    localparam int WOFF = calc_woff(WORDS_PER_LINE);

    logic [NUM_LINES-1:0]  valid;
    logic [TAG_W-1:0]      tags [NUM_LINES];
    logic [DATA_WIDTH-1:0] data [NUM_LINES*WORDS_PER_LINE];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_word  = data[{rd_idx, rd_woff}];

    // A flush in the same cycle as a tag write must also kill the line being
    // completed, so flush_all has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush_all) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tags[wr_idx] <= wr_tag;
        end
        if (wr_en) begin
            data[{wr_idx, wr_woff}] <= wr_data;
        end
    end

endmodule

// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped read-only instruction cache with burst line refill
//
// Purpose: zero-latency hits from pc; a miss stalls fetch, issues one line
// request and accepts WORDS_PER_LINE ascending beats. flush invalidates all lines.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   pc, fetch_en, flush        - fetch address/request, invalidate-all
//   instr, instr_valid, stall  - fetched word, hit indication, fetch stall
//   mem_req, mem_addr, mem_ack - refill request handshake (line-aligned address)
//   mem_rvalid, mem_rdata      - refill beats

module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] pc,
    input  logic                     fetch_en,
    input  logic                     flush,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     instr_valid,
    output logic                     stall,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ack,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int WOFF  = calc_woff(WORDS_PER_LINE);
    localparam int IDX   = calc_idx(NUM_LINES);
    localparam int TAG_W = calc_tag_w(ADDRESS_WIDTH, NUM_LINES, WORDS_PER_LINE);
    localparam int LINE_W = TAG_W + IDX;

    cache_state_t      state;
    logic [WOFF-1:0]   beat;
    logic              flush_pend;
    logic [LINE_W-1:0] line_hi;    // captured {tag, index} of the line being refilled

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_WIDTH-1:0] rd_word;
    logic              hit;
    logic              beat_we;
    logic              last_beat;
    logic              flush_all;

    // Byte offset never selects anything for 32-bit instruction fetch.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, pc[1:0]};

    assign hit = (state == IDLE) && fetch_en && !flush && rd_valid
                 && (rd_tag == pc[ADDRESS_WIDTH-1 -: TAG_W]);

    assign instr       = rd_word;
    assign instr_valid = hit;
    assign stall       = fetch_en & ~hit;

    assign beat_we   = (state == FILL) && mem_rvalid;
    assign last_beat = (beat == WOFF'(WORDS_PER_LINE - 1));

    // A flush seen during the refill (pending, or in the final beat itself)
    // also invalidates the freshly completed line.
    assign flush_all = ((state == IDLE) && flush)
                       || (beat_we && last_beat && (flush_pend || flush));

    instr_cache_store #(
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (pc[WOFF+2 +: IDX]),
        .rd_woff   (pc[2 +: WOFF]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .wr_en     (beat_we),
        .wr_idx    (line_hi[0 +: IDX]),
        .wr_woff   (beat),
        .wr_data   (mem_rdata),
        .tag_we    (beat_we && last_beat),
        .wr_tag    (line_hi[IDX +: TAG_W]),
        .flush_all (flush_all)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            flush_pend <= 1'b0;
            line_hi    <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en && !flush && !hit) begin
                        line_hi  <= pc[ADDRESS_WIDTH-1:WOFF+2];
                        mem_addr <= {pc[ADDRESS_WIDTH-1:WOFF+2], {(WOFF+2){1'b0}}};
                        mem_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    // Beats are not accepted here, not even in the ack cycle.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        beat    <= '0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        beat <= beat + WOFF'(1);
                        if (last_beat) begin
                            flush_pend <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - directed self-checking bench for instr_cache

module tb_instr_cache;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] pc, instr, mem_addr, mem_rdata;
    logic        fetch_en, flush, instr_valid, stall, mem_req, mem_ack, mem_rvalid;

    logic [31:0] p_pc, p_instr, p_mem_addr, p_mem_rdata;
    logic        p_fetch_en, p_flush, p_instr_valid, p_stall, p_mem_req, p_mem_ack, p_mem_rvalid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_cache u_dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en), .flush(flush),
        .instr(instr), .instr_valid(instr_valid), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    instr_cache #(.NUM_LINES(4), .WORDS_PER_LINE(8)) u_dut_sweep (
        .clk(clk), .rst_n(rst_n), .pc(p_pc), .fetch_en(p_fetch_en), .flush(p_flush),
        .instr(p_instr), .instr_valid(p_instr_valid), .stall(p_stall),
        .mem_req(p_mem_req), .mem_addr(p_mem_addr), .mem_ack(p_mem_ack),
        .mem_rvalid(p_mem_rvalid), .mem_rdata(p_mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered in an IDLE cycle where pc misses. Acks in the req_cycles-th REQ
    // cycle (with junk beats driven throughout REQ), then plays pat[0..pat_len-1]
    // as the rvalid sequence; beat k carries base*(k+1). flush is pulsed with
    // beat number flush_beat (-1: never). Returns in the cycle after the last beat.
    task automatic do_refill(input logic [31:0] exp_addr, input int req_cycles,
                             input logic [31:0] base, input logic [7:0] pat,
                             input int pat_len, input int flush_beat);
        int k;
        chk("miss_stall", {31'b0, stall}, 32'd1);
        chk("miss_valid", {31'b0, instr_valid}, 32'd0);
        tick;
        for (int i = 0; i < req_cycles; i++) begin
            chk("req_high", {31'b0, mem_req}, 32'd1);
            chk("req_addr", mem_addr, exp_addr);
            chk("req_stall", {31'b0, stall}, 32'd1);
            mem_ack    = (i == req_cycles - 1);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEADBEEF;
            tick;
        end
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        chk("req_drop", {31'b0, mem_req}, 32'd0);
        k = 0;
        for (int i = 0; i < pat_len; i++) begin
            chk("fill_valid", {31'b0, instr_valid}, 32'd0);
            chk("fill_stall", {31'b0, stall}, 32'd1);
            mem_rvalid = pat[i];
            mem_rdata  = pat[i] ? base * (k + 1) : 32'hBAD0BAD0;
            flush      = pat[i] && (k == flush_beat);
            if (pat[i]) k++;
            tick;
        end
        mem_rvalid = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; fetch_en = 1'b1; flush = 1'b0; pc = 32'h0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        p_pc = 32'h0; p_fetch_en = 1'b0; p_flush = 1'b0;
        p_mem_ack = 1'b0; p_mem_rvalid = 1'b0; p_mem_rdata = 32'h0;
        tick;
        tick;
        // Reset values
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd1);
        chk("rst_sweep_req", {31'b0, p_mem_req}, 32'd0);
        rst_n = 1'b1;
        pc    = 32'h10;

        // 1: cold miss, ack after 2 REQ cycles, consecutive beats 0x11..0x44
        do_refill(32'h10, 2, 32'h11, 8'h0F, 4, -1);
        chk("c1_valid", {31'b0, instr_valid}, 32'd1);
        chk("c1_instr", instr, 32'h11);
        chk("c1_stall", {31'b0, stall}, 32'd0);
        pc = 32'h1C;
        #1;
        chk("c1_w3", instr, 32'h44);
        chk("c1_w3_valid", {31'b0, instr_valid}, 32'd1);

        // 2: conflict at same index, different tag
        pc = 32'h110;
        #1;
        do_refill(32'h110, 1, 32'h55, 8'h0F, 4, -1);
        chk("c2_instr", instr, 32'h55);
        chk("c2_valid", {31'b0, instr_valid}, 32'd1);

        // 3: 0x10 was evicted; refill it with gapped beats 1,0,0,1,1,0,1
        pc = 32'h10;
        #1;
        do_refill(32'h10, 3, 32'h11, 8'b1011001, 7, -1);
        chk("c3_w0", instr, 32'h11);
        chk("c3_valid", {31'b0, instr_valid}, 32'd1);
        pc = 32'h14; #1; chk("c3_w1", instr, 32'h22);
        pc = 32'h18; #1; chk("c3_w2", instr, 32'h33);
        pc = 32'h1C; #1; chk("c3_w3", instr, 32'h44);
        pc = 32'h110; #1; chk("c3_old_gone", {31'b0, instr_valid}, 32'd0);
        pc = 32'h10; #1;

        // 4: flush on the 2nd beat; the filled line must not survive
        pc = 32'h20;
        #1;
        do_refill(32'h20, 2, 32'h61, 8'h0F, 4, 1);
        chk("c4_after_flush", {31'b0, instr_valid}, 32'd0);
        do_refill(32'h20, 1, 32'h70, 8'h0F, 4, -1);
        chk("c4_refetch", instr, 32'h70);
        chk("c4_refetch_valid", {31'b0, instr_valid}, 32'd1);
        pc = 32'h10; #1;
        chk("c4_other_flushed", {31'b0, instr_valid}, 32'd0);
        fetch_en = 1'b0;
        #1;
        chk("c4_idle_stall", {31'b0, stall}, 32'd0);

        // 5: reset after 2 beats, then stray beats
        tick;
        fetch_en = 1'b1;
        pc = 32'h30;
        tick;
        chk("c5_req_addr", mem_addr, 32'h30);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hA0 + i;
            tick;
        end
        rst_n = 1'b0;
        mem_rvalid = 1'b0;
        #1;
        chk("c5_rst_req", {31'b0, mem_req}, 32'd0);
        chk("c5_rst_valid", {31'b0, instr_valid}, 32'd0);
        tick;
        rst_n = 1'b1;
        fetch_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD;
            tick;
            chk("c5_stray_req", {31'b0, mem_req}, 32'd0);
        end
        mem_rvalid = 1'b0;
        fetch_en = 1'b1;
        #1;
        do_refill(32'h30, 1, 32'h90, 8'h0F, 4, -1);
        chk("c5_w0", instr, 32'h90);
        pc = 32'h34; #1;
        chk("c5_w1", instr, 32'h120);
        chk("c5_w1_valid", {31'b0, instr_valid}, 32'd1);
        fetch_en = 1'b0;

        // 6: NUM_LINES=4, WORDS_PER_LINE=8, pc=0x3C
        p_fetch_en = 1'b1;
        p_pc = 32'h3C;
        #1;
        chk("c6_miss_stall", {31'b0, p_stall}, 32'd1);
        tick;
        chk("c6_req", {31'b0, p_mem_req}, 32'd1);
        chk("c6_addr", p_mem_addr, 32'h20);
        p_mem_ack = 1'b1;
        tick;
        p_mem_ack = 1'b0;
        chk("c6_req_drop", {31'b0, p_mem_req}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("c6_fill_valid", {31'b0, p_instr_valid}, 32'd0);
            p_mem_rvalid = 1'b1;
            p_mem_rdata  = 32'h100 + i;
            tick;
        end
        p_mem_rvalid = 1'b0;
        chk("c6_valid", {31'b0, p_instr_valid}, 32'd1);
        chk("c6_w7", p_instr, 32'h107);
        p_pc = 32'h20; #1;
        chk("c6_w0", p_instr, 32'h100);
        p_fetch_en = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
